// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Boot-time program loader for the LEGv8 instruction memory.
//             Takes a valid/ready byte stream of the form
//               LEN_LO, LEN_HI, then 4*N data bytes (each word little-endian),
//             writes word i to imem word address i, and holds the core in
//             reset until the whole image has been written.
//  Options  : CHECKSUM_EN - when defined, one extra byte follows the data and
//             must equal the XOR of all 4*N data bytes; a mismatch aborts the
//             load into ERROR.
//  Ports    : clock, reset_n (sync, active-low), start (load request pulse)
//             in_data/in_valid/in_ready    byte stream
//             imem_we/imem_addr/imem_wdata instruction-memory write port
//             cpu_rst_n                    core reset (0 = held)
//             done, error, words_loaded    load status
//  Revision : 1.0  initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  // Capacity is held in 17 bits so that 2**16 still fits.
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR0   = 3'd1,
    S_HDR1   = 3'd2,
    S_DATA   = 3'd3,
`ifdef CHECKSUM_EN
    S_CSUM   = 3'd4,
`endif
    S_SETTLE = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;   // bytes 0..2 of the word being assembled
`ifdef CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic        take;
  logic [15:0] hdr_len;
  logic [15:0] words_next;
  logic        last_word;

  // Ready depends on state alone so a source can rely on it without
  // any combinational path back from in_valid.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_HDR0, S_HDR1, S_DATA: in_ready = 1'b1;
`ifdef CHECKSUM_EN
      S_CSUM:                 in_ready = 1'b1;
`endif
      default:                in_ready = 1'b0;
    endcase
  end

  assign take       = in_valid & in_ready;
  assign hdr_len    = {in_data, len_lo};
  assign words_next = words_loaded + 16'd1;
  assign last_word  = (words_next == len);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      len_lo       <= 8'd0;
      len          <= 16'd0;
      byte_cnt     <= 2'd0;
      word_buf     <= 24'd0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      cpu_rst_n    <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 16'd0;
`ifdef CHECKSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      // Write strobe is a one-cycle pulse; address/data simply hold.
      imem_we <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state        <= S_HDR0;
            words_loaded <= 16'd0;
            done         <= 1'b0;
            error        <= 1'b0;
            byte_cnt     <= 2'd0;
            cpu_rst_n    <= 1'b0;   // re-holds the core when reloading from DONE
`ifdef CHECKSUM_EN
            csum         <= 8'd0;
`endif
          end
        end

        S_HDR0: begin
          if (take) begin
            len_lo <= in_data;
            state  <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (take) begin
            len <= hdr_len;
            // Rejecting oversize images here is what keeps imem_addr from
            // ever wrapping.
            if ((hdr_len == 16'd0) || ({1'b0, hdr_len} > MAX_WORDS)) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (take) begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef CHECKSUM_EN
            csum     <= csum ^ in_data;
`endif
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= in_data;
              2'd1: word_buf[15:8]  <= in_data;
              2'd2: word_buf[23:16] <= in_data;
              default: begin
                imem_we      <= 1'b1;
                imem_addr    <= words_loaded[ADDR_W-1:0];
                imem_wdata   <= {in_data, word_buf};
                words_loaded <= words_next;
                if (last_word) begin
`ifdef CHECKSUM_EN
                  state <= S_CSUM;
`else
                  state <= S_SETTLE;
`endif
                end
              end
            endcase
          end
        end

`ifdef CHECKSUM_EN
        S_CSUM: begin
          if (take) begin
            if (in_data == csum) begin
              state <= S_SETTLE;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
`endif

        // One spare cycle so the last write has landed before the core runs.
        S_SETTLE: begin
          state     <= S_DONE;
          done      <= 1'b1;
          cpu_rst_n <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader. Expected imem writes are
//             queued as bytes are driven and popped by a write monitor.
//             Checksum-specific steps run only when CHECKSUM_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              done;
  logic              error;
  logic [15:0]       words_loaded;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst_n    (cpu_rst_n),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [39:0] exp_q[$];     // {addr, data} of expected writes, in order
  logic [31:0] img[$];       // image currently being sent
  int          we_count    = 0;
  int          cyc         = 0;
  int          last_we_cyc = -1;
  logic [7:0]  last_addr   = 8'h00;
  logic        prev_we     = 1'b0;
  logic        prev_rst_n  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor / scoreboard, sampled on the inactive edge.
  always @(negedge clock) begin
    cyc++;
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {imem_addr, imem_wdata}, 64'hDEAD);
      end else begin
        chk("imem_write", {24'd0, imem_addr, imem_wdata}, {24'd0, exp_q.pop_front()});
      end
      chk("we_single_cycle", prev_we, 1'b0);
      we_count++;
      last_we_cyc = cyc;
      last_addr   = imem_addr;
    end
    if (cpu_rst_n && !prev_rst_n) begin
      chk("core_release_after_write", (cyc > last_we_cyc), 1'b1);
      chk("core_release_queue_empty", exp_q.size(), 0);
    end
    prev_we    = imem_we;
    prev_rst_n = cpu_rst_n;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte until accepted (bounded), optionally with start held high.
  task automatic send_byte(input logic [7:0] b, input bit st);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    start    = st;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", in_ready, 1'b1);
    end else begin
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Send header + img words; gaps and start pulses are randomly interleaved.
  task automatic load_image(input logic [15:0] n, input int gap_pct, input bit starts,
                            input bit bad_csum);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    logic [31:0] w;
    send_byte(n[7:0], 1'b0);
    send_byte(n[15:8], 1'b0);
    for (int i = 0; i < int'(n); i++) begin
      w = img[i];
      exp_q.push_back({8'(i), w});
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        x = x ^ b;
        if (int'($urandom_range(99)) < gap_pct) begin
          repeat ($urandom_range(1, 3)) begin
            start = starts;
            tick();
          end
          start = 1'b0;
        end
        send_byte(b, starts && ($urandom_range(3) == 0));
      end
    end
`ifdef CHECKSUM_EN
    send_byte(bad_csum ? (x ^ 8'h01) : x, 1'b0);
`else
    if (bad_csum) x = x ^ 8'h01;   // no checksum byte in this build
`endif
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      tick();
      n++;
    end
    chk("wait_end_timeout", (done || error), 1'b1);
  endtask

  task automatic set_test2_image();
    img.delete();
    img.push_back(32'hD2800020);
    img.push_back(32'h91000421);
  endtask

  initial begin
    int wc;
    reset_n  = 1'b0;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;

    // 1: reset state
    repeat (2) tick();
    chk("rst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_imem_we", imem_we, 1'b0);
    chk("rst_words", words_loaded, 16'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 1'b0);

    // 2: two-word image, back-to-back bytes
    set_test2_image();
    wc = we_count;
    pulse_start();
    chk("hdr0_in_ready", in_ready, 1'b1);
    load_image(16'd2, 0, 1'b0, 1'b0);
    wait_end(20);
    chk("t2_done", done, 1'b1);
    chk("t2_error", error, 1'b0);
    chk("t2_cpu_rst_n", cpu_rst_n, 1'b1);
    chk("t2_words", words_loaded, 16'd2);
    chk("t2_we_pulses", we_count - wc, 2);
    chk("t2_addr_hold", {imem_addr, imem_wdata}, {8'h01, 32'h91000421});

    // bytes offered in DONE are not consumed
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("done_ignore_bytes", {done, words_loaded}, {1'b1, 16'd2});

    // 3: zero length -> ERROR, then recover via start
    pulse_start();
    chk("restart_holds_core", cpu_rst_n, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("t3_error", error, 1'b1);
    chk("t3_in_ready", in_ready, 1'b0);
    chk("t3_cpu_rst_n", cpu_rst_n, 1'b0);
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("t3_error_sticky", {error, words_loaded}, {1'b1, 16'd0});
    pulse_start();
    chk("t3_recover_error", error, 1'b0);
    chk("t3_recover_ready", in_ready, 1'b1);

    // 4: N=257 rejected, N=256 accepted up to the last address
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("t4_n257_error", error, 1'b1);
    img.delete();
    for (int i = 0; i < 256; i++) img.push_back($urandom);
    pulse_start();
    load_image(16'd256, 0, 1'b0, 1'b0);
    wait_end(20);
    chk("t4_n256_done", {done, error}, 2'b10);
    chk("t4_words", words_loaded, 16'd256);
    chk("t4_last_addr", last_addr, 8'hFF);

    // 5: random gaps with start pulses during the load
    img.delete();
    for (int i = 0; i < 8; i++) img.push_back($urandom);
    pulse_start();
    load_image(16'd8, 40, 1'b1, 1'b0);
    wait_end(20);
    chk("t5_done", {done, error}, 2'b10);
    chk("t5_words", words_loaded, 16'd8);
    chk("t5_queue_empty", exp_q.size(), 0);

`ifdef CHECKSUM_EN
    // 6a: wrong checksum -> ERROR, words already written, core held
    set_test2_image();
    pulse_start();
    load_image(16'd2, 0, 1'b0, 1'b1);
    wait_end(20);
    chk("t6_bad_csum_error", {done, error}, 2'b01);
    chk("t6_bad_csum_core", cpu_rst_n, 1'b0);
    chk("t6_bad_csum_words", words_loaded, 16'd2);
`endif

    // 6b: reset_n mid-DATA, then a clean load
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    exp_q.push_back({8'h00, 32'hCAFEF00D});
    send_byte(8'h0D, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'hFE, 1'b0);
    send_byte(8'hCA, 1'b0);
    send_byte(8'h11, 1'b0);
    reset_n = 1'b0;
    tick();
    chk("t6_rst_in_ready", in_ready, 1'b0);
    chk("t6_rst_core", cpu_rst_n, 1'b0);
    chk("t6_rst_status", {done, error, words_loaded}, 18'd0);
    reset_n = 1'b1;
    tick();
    chk("t6_rst_queue", exp_q.size(), 0);
    set_test2_image();
    pulse_start();
    load_image(16'd2, 20, 1'b0, 1'b0);
    wait_end(20);
    chk("t6_reload_done", {done, error, cpu_rst_n}, 3'b101);
    chk("t6_reload_words", words_loaded, 16'd2);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
